// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI master that shifts one NUM_BYTES-byte frame per start with ss_n held low throughout
module spi_frame_master #(
  parameter int   NUM_BYTES = 2,
  parameter int   CLK_DIV   = 4,
  parameter logic CPOL      = 1'b0,
  parameter logic CPHA      = 1'b0,
  parameter int   IBG       = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] tx_frame,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] rx_frame,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic                   ss_n
);
  localparam int FW = 8 * NUM_BYTES;
  localparam int MAXC = CLK_DIV > IBG ? CLK_DIV : IBG;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] CD_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] IBG_M1 = CW'(IBG > 0 ? IBG - 1 : 0);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic half_q, half_d;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [FW-1:0] tx_q, tx_d, rx_q, rx_d, frame_q, frame_d;
  logic done_q, done_d, busy_q, busy_d, sclk_q, sclk_d;
  assign busy = busy_q;
  assign done = done_q;
  assign rx_frame = frame_q;
  assign sclk = sclk_q;
  assign mosi = tx_q[FW-1];
  assign ss_n = ~busy_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= CPOL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
    end
  end
  // the tx register shifts in zeros, so mosi falls back to 0 once the last bit is out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cnt_d   = CD_M1;
        half_d  = 1'b0;
        bit_d   = '0;
        byte_d  = '0;
        tx_d    = tx_frame;
      end
      SETUP: begin
        cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : CD_M1;
        state_d = cnt_q != '0 ? SETUP : XFER;
      end
      XFER: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!half_q) begin
        half_d = 1'b1;
        cnt_d  = CD_M1;
        rx_d   = {rx_q[FW-2:0], miso};
      end else begin
        half_d = 1'b0;
        cnt_d  = CD_M1;
        tx_d   = tx_q << 1;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d = byte_q == LAST_BYTE ? '0 : byte_q + 1'b1;
          if (byte_q == LAST_BYTE) begin
            state_d = HOLD;
          end else if (IBG > 0) begin
            state_d = GAP;
            cnt_d   = IBG_M1;
          end
        end
      end
      GAP: begin
        cnt_d   = cnt_q != '0 ? cnt_q - 1'b1 : CD_M1;
        state_d = cnt_q != '0 ? GAP : XFER;
      end
      HOLD: if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
        frame_d = rx_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    sclk_d = state_d == XFER ? (CPOL ^ CPHA ^ half_d) : CPOL;
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: randomized frames over several parameter sets, SPI slave model and scoreboard
module tb_spi_frame_master;
  localparam int NC = 5;
  localparam int NBA [NC] = '{2, 2, 2, 2, 3};
  localparam int CDA [NC] = '{2, 2, 3, 1, 1};
  localparam int POA [NC] = '{0, 0, 1, 1, 0};
  localparam int PHA [NC] = '{0, 1, 0, 1, 0};
  localparam int IGA [NC] = '{0, 4, 1, 0, 0};
  localparam logic [23:0] FR0 [NC] = '{24'h2A5C, 24'hC381, 24'hC381, 24'hC381, 24'hA5F00F};
  logic clk = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int fin_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int NB = NBA[g];
    localparam int FW = 8 * NB;
    localparam int CD = CDA[g];
    localparam int IG = IGA[g];
    localparam logic POL = 1'(POA[g]);
    localparam logic PH = 1'(PHA[g]);
    localparam int LAT = 1 + CD * (2 + 16 * NB) + IG * (NB - 1);
    logic rst, start, busy, done, sclk, mosi, miso, ss_n;
    logic [FW-1:0] tx_frame, rx_frame, sdata, sd_cur, cap;
    logic [FW-1:0] exp_rx[$];
    logic [FW-1:0] exp_tx[$];
    int exp_cyc[$];
    int k = 0;
    spi_frame_master #(.NUM_BYTES(NB), .CLK_DIV(CD), .CPOL(POL), .CPHA(PH), .IBG(IG)) dut (
      .clk(clk), .reset(rst), .start(start), .tx_frame(tx_frame), .busy(busy), .done(done),
      .rx_frame(rx_frame), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );
    // slave: shifts out on the non-sampling edge, captures mosi on the sampling edge
    assign miso = (k >= 0 && k < FW) ? sd_cur[FW-1-k] : 1'b0;
    always @(negedge ss_n) begin
      sd_cur = sdata;
      cap = '0;
      k = PH ? -1 : 0;
    end
    always @(sclk) if (ss_n === 1'b0) begin
      if (sclk == (POL ^ PH)) k = k + 1;
      else cap = {cap[FW-2:0], mosi};
    end
    always @(negedge clk) if (!rst && done) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cfg%0d unexpected_done at cycle %0d", g, cyc);
      end else begin
        chk(g, "rx_frame", rx_frame, exp_rx.pop_front());
        chk(g, "mosi_stream", cap, exp_tx.pop_front());
        chk(g, "done_cycle", cyc, exp_cyc.pop_front());
        chk(g, "ss_n_at_done", ss_n, 1);
        chk(g, "sclk_idle_at_done", sclk, POL);
        chk(g, "busy_at_done", busy, 0);
      end
    end
    initial begin
      int n;
      logic hold;
      logic [FW-1:0] t;
      rst = 1'b1;
      start = 1'b0;
      tx_frame = '0;
      sdata = '0;
      repeat (3) @(negedge clk);
      chk(g, "reset_ss_n", ss_n, 1);
      chk(g, "reset_sclk", sclk, POL);
      chk(g, "reset_busy", busy, 0);
      chk(g, "reset_done", done, 0);
      chk(g, "reset_rx", rx_frame, 0);
      chk(g, "reset_mosi", mosi, 0);
      rst = 1'b0;
      for (int f = 0; f < 10; f++) begin
        n = 0;
        while (busy && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (busy) begin
          total++;
          bad++;
          $display("FAIL cfg%0d idle_wait expired after %0d cycles", g, n);
          break;
        end
        if (!start) repeat ($urandom_range(0, 2)) @(negedge clk);
        hold = f < 8 && $urandom_range(0, 3) == 0;
        t = f == 0 ? FW'(FR0[g]) : FW'($urandom);
        tx_frame = t;
        sdata = f == 0 ? FW'(FR0[g]) : FW'($urandom);
        start = 1'b1;
        if (f != 8) begin
          exp_rx.push_back(sdata);
          exp_tx.push_back(t);
          exp_cyc.push_back(cyc + LAT);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk(g, "ss_n_after_accept", ss_n, 0);
        chk(g, "busy_after_accept", busy, 1);
        chk(g, "mosi_first_bit", mosi, t[FW-1]);
        if (f == 8) begin
          repeat (29) @(negedge clk);
          rst = 1'b1;
          #1;
          chk(g, "abort_ss_n", ss_n, 1);
          chk(g, "abort_sclk", sclk, POL);
          chk(g, "abort_busy", busy, 0);
          chk(g, "abort_rx", rx_frame, 0);
          chk(g, "abort_done", done, 0);
          @(negedge clk);
          rst = 1'b0;
        end else if (f % 3 == 1 && !hold) begin
          repeat (9) @(negedge clk);
          start = 1'b1;
          tx_frame = FW'($urandom);
          @(negedge clk);
          start = 1'b0;
          repeat (LAT - 16) @(negedge clk);
          start = 1'b1;
          tx_frame = FW'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
      end
      n = 0;
      while (exp_rx.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (exp_rx.size() != 0) begin
        total++;
        bad++;
        $display("FAIL cfg%0d missing_done: %0d frames never completed", g, exp_rx.size());
      end
      repeat (5) @(negedge clk);
      fin_cnt++;
    end
  end
  initial begin
    int n;
    n = 0;
    while (fin_cnt < NC && n < 50000) begin
      @(negedge clk);
      n++;
    end
    if (fin_cnt < NC) begin
      total++;
      bad++;
      $display("FAIL timeout: only %0d of %0d configurations finished", fin_cnt, NC);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
